// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NCH-channel round-robin arbitrated mux with valid/ready handshakes and one output register.
// Optional build macro RR_ARB_MUX_CHID_EN adds out_ch, the source channel index of the current beat.
module rr_arb_mux #(
    parameter int  WIDTH = 5,
    parameter int  NCH   = 4,
    localparam int CW    = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
`ifdef RR_ARB_MUX_CHID_EN
    output logic [CW-1:0]        out_ch,
`endif
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    last_grant_q, last_grant_d;
`ifdef RR_ARB_MUX_CHID_EN
    logic [CW-1:0]    out_ch_q, out_ch_d;
`endif

    logic [WIDTH-1:0] ch_data [NCH];
    logic [CW-1:0]    grant;
    logic [CW-1:0]    idx;
    logic             found;
    logic             any_valid;
    logic             load;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign any_valid = |in_valid;
    assign load      = !out_valid_q || out_ready;

    // Search upward from the channel after the last accepted one, wrapping at NCH-1.
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant = last_grant_q;
        idx   = last_grant_q;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = (idx == CW'(NCH - 1)) ? '0 : idx + CW'(1);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (load && any_valid && !rst) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        last_grant_d = last_grant_q;
`ifdef RR_ARB_MUX_CHID_EN
        out_ch_d     = out_ch_q;
`endif
        if (load) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d   = ch_data[grant];
                last_grant_d = grant;
`ifdef RR_ARB_MUX_CHID_EN
                out_ch_d     = grant;
`endif
            end
        end
    end

    // Reset parks last_grant on NCH-1 so the first grant after reset favours channel 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            last_grant_q <= CW'(NCH - 1);
`ifdef RR_ARB_MUX_CHID_EN
            out_ch_q     <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            last_grant_q <= last_grant_d;
`ifdef RR_ARB_MUX_CHID_EN
            out_ch_q     <= out_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef RR_ARB_MUX_CHID_EN
    assign out_ch    = out_ch_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (WIDTH=5, NCH=4): directed cases plus a queue-based scoreboard.
// Define RR_ARB_MUX_CHID_EN for both files to also check out_ch.
module tb_rr_arb_mux;

    localparam int WIDTH = 5;
    localparam int NCH   = 4;
    localparam int CW    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic                 out_ready;
`ifdef RR_ARB_MUX_CHID_EN
    logic [CW-1:0]        out_ch;
`endif

    typedef struct packed {
        logic [CW-1:0]    ch;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    m_last;
    int    total = 0;
    int    bad   = 0;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
`ifdef RR_ARB_MUX_CHID_EN
        .out_ch   (out_ch),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_data(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    // One clock cycle: check outputs and in_ready against the reference model at the
    // falling edge, update the scoreboard for the coming rising edge, return 1 time unit after it.
    task automatic cycle();
        logic [NCH-1:0] exp_ready;
        logic [CW-1:0]  gi;
        logic           load;
        logic           any;
        int             g;
        int             idx;
        beat_t          b;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(sb_q[0].data));
`ifdef RR_ARB_MUX_CHID_EN
            check("out_ch", 32'(out_ch), 32'(sb_q[0].ch));
`endif
        end
        any  = |in_valid;
        load = (sb_q.size() == 0) || out_ready;
        g    = -1;
        for (int k = 1; k <= NCH; k++) begin
            idx = (m_last + k) % NCH;
            if (g < 0 && in_valid[idx[CW-1:0]]) g = idx;
        end
        gi        = CW'(g);
        exp_ready = '0;
        if (!rst && load && any) exp_ready[gi] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (rst) begin
            sb_q.delete();
            m_last = NCH - 1;
        end else if (load) begin
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            if (any) begin
                b.ch   = gi;
                b.data = in_data[g*WIDTH +: WIDTH];
                sb_q.push_back(b);
                m_last = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        set_data(5'h01, 5'h02, 5'h03, 5'h04);
        m_last    = NCH - 1;
        @(posedge clk);
        #1;

        // Reset with all channels requesting.
        repeat (2) cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
`ifdef RR_ARB_MUX_CHID_EN
        check("rst_out_ch", 32'(out_ch), 32'd0);
`endif
        rst = 1'b0;
        #1 check("first_ready", 32'(in_ready), 32'b0001);

        // Round robin, all valid, ch i data = i+1.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_data", 32'(out_data), 32'((i % NCH) + 1));
`ifdef RR_ARB_MUX_CHID_EN
            check("rr_ch", 32'(out_ch), 32'(i % NCH));
`endif
        end
        in_valid = '0;
        repeat (2) cycle();

        // Single channel 2.
        in_valid = 4'b0100;
        set_data(5'h00, 5'h00, 5'h15, 5'h00);
        #1 check("single_ready", 32'(in_ready), 32'b0100);
        cycle();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h15);
        in_valid = '0;
        cycle();
        check("single_drop", 32'(out_valid), 32'd0);

        // Backpressure: ch3 loads 5'h0A into the empty register, then out_ready stays low.
        in_valid  = 4'hF;
        set_data(5'h01, 5'h02, 5'h03, 5'h0A);
        out_ready = 1'b0;
        cycle();
        check("bp_load", 32'(out_data), 32'h0A);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 32'(in_ready), 32'b0000);
            cycle();
            check("bp_hold", 32'(out_data), 32'h0A);
        end
        out_ready = 1'b1;
        #1 check("bp_release", 32'(in_ready), 32'b0001);
        cycle();
        check("bp_next", 32'(out_data), 32'h01);
        in_valid = '0;
        repeat (2) cycle();

        // Skip/wrap from last_grant=0 with only ch0 and ch3 valid.
        in_valid = 4'b1001;
        set_data(5'h11, 5'h00, 5'h00, 5'h1C);
        #1 check("wrap_ready3", 32'(in_ready), 32'b1000);
        cycle();
        check("wrap_data3", 32'(out_data), 32'h1C);
        #1 check("wrap_ready0", 32'(in_ready), 32'b0001);
        cycle();
        check("wrap_data0", 32'(out_data), 32'h11);
        in_valid = '0;
        repeat (2) cycle();

        // Random traffic with backpressure and one reset mid-stream.
        for (int n = 0; n < 300; n++) begin
            rst       = (n == 150);
            in_valid  = NCH'($urandom);
            in_data   = (NCH*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst       = 1'b0;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
